// File: rtl/seq_mult_pkg.sv
// Shared state encoding and width helpers for the shift-add seq_multiplier.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    function automatic int prod_width(input int width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/mult_add_stage.sv
// WIDTH-bit combinational adder with carry-out: one partial-product step.
module mult_add_stage #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b};

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier, WIDTH RUN cycles per product.
// Optional two's-complement mode with macro SEQ_MULTIPLIER_SIGNED_EN.
module seq_multiplier
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
`ifdef SEQ_MULTIPLIER_SIGNED_EN
    input  logic               signed_mode,
`endif
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] p
);

    localparam int CW = cnt_width(WIDTH);
    localparam int PW = prod_width(WIDTH);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_mcand;
    logic [PW-1:0]    r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_neg;
    logic [PW-1:0]    r_p;

    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic             w_neg;
    logic [WIDTH-1:0] w_addend;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic [PW-1:0]    w_acc_nxt;
    logic [PW-1:0]    w_prod;

`ifdef SEQ_MULTIPLIER_SIGNED_EN
    // Signed mode runs the unsigned datapath on magnitudes; sign is restored at the end
    always_comb begin
        w_a_mag = a;
        w_b_mag = b;
        w_neg   = 1'b0;
        if (signed_mode) begin
            if (a[WIDTH-1]) w_a_mag = -a;
            if (b[WIDTH-1]) w_b_mag = -b;
            w_neg = a[WIDTH-1] ^ b[WIDTH-1];
        end
    end
`else
    assign w_a_mag = a;
    assign w_b_mag = b;
    assign w_neg   = 1'b0;
`endif

    assign w_addend = r_acc[0] ? r_mcand : '0;

    mult_add_stage #(
        .WIDTH (WIDTH)
    ) u_add (
        .i_a    (r_acc[PW-1:WIDTH]),
        .i_b    (w_addend),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    assign w_acc_nxt = {w_cout, w_sum, r_acc[WIDTH-1:1]};
    assign w_prod    = r_neg ? -w_acc_nxt : w_acc_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (start) w_state_nxt = RUN;
            RUN:     if (r_cnt == '0) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Product lands in p on the edge entering DONE so it is valid with done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcand <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_neg   <= 1'b0;
            r_p     <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_mcand <= w_a_mag;
                        r_acc   <= {{WIDTH{1'b0}}, w_b_mag};
                        r_cnt   <= CNT_LOAD;
                        r_neg   <= w_neg;
                    end
                end
                RUN: begin
                    r_acc <= w_acc_nxt;
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == '0) r_p <= w_prod;
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);
    assign p    = r_p;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier (WIDTH=8 and WIDTH=4 instances).
module tb_seq_multiplier;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start8 = 1'b0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        sm8 = 1'b0;
    logic        busy8;
    logic        done8;
    logic [15:0] p8;

    logic        start4 = 1'b0;
    logic [3:0]  a4 = '0;
    logic [3:0]  b4 = '0;
    logic        sm4 = 1'b0;
    logic        busy4;
    logic        done4;
    logic [7:0]  p4;

    int n_cmp = 0;
    int n_bad = 0;
    int dn8   = 0;
    logic [15:0] q8[$];
    logic [15:0] last_p8 = '0;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        sm;
        logic [15:0] exp;
        string       nm;
    } vec_t;

    always #5 clk = ~clk;

    seq_multiplier #(.WIDTH(8)) dut8 (
        .clk         (clk),
        .rst         (rst),
        .start       (start8),
        .a           (a8),
        .b           (b8),
`ifdef SEQ_MULTIPLIER_SIGNED_EN
        .signed_mode (sm8),
`endif
        .busy        (busy8),
        .done        (done8),
        .p           (p8)
    );

    seq_multiplier #(.WIDTH(4)) dut4 (
        .clk         (clk),
        .rst         (rst),
        .start       (start4),
        .a           (a4),
        .b           (b4),
`ifdef SEQ_MULTIPLIER_SIGNED_EN
        .signed_mode (sm4),
`endif
        .busy        (busy4),
        .done        (done4),
        .p           (p4)
    );

    task automatic chk(input bit ok, input string nm,
                       input longint act, input longint exp);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding product
    always @(negedge clk) begin
        if (!rst && done8) begin
            dn8++;
            chk(q8.size() > 0, "sb_expected_done", q8.size(), 1);
            if (q8.size() > 0) begin
                logic [15:0] e;
                e = q8.pop_front();
                chk(p8 == e, "sb_p8", p8, e);
            end
        end
    end

    task automatic run8(input logic [7:0] ta, input logic [7:0] tb,
                        input logic sm, input logic [15:0] exp,
                        input string nm);
        int lat;
        int bcnt;
        a8 = ta;
        b8 = tb;
        sm8 = sm;
        start8 = 1'b1;
        q8.push_back(exp);
        @(negedge clk);
        start8 = 1'b0;
        lat = 1;
        bcnt = 0;
        while (!done8 && lat < 40) begin
            if (busy8) bcnt++;
            chk(p8 == last_p8, {nm, "_p_hold_run"}, p8, last_p8);
            @(negedge clk);
            lat++;
        end
        chk(lat == 9, {nm, "_latency"}, lat, 9);
        chk(bcnt == 8, {nm, "_busy_cycles"}, bcnt, 8);
        if (lat >= 40 && q8.size() > 0) void'(q8.pop_back());
        last_p8 = exp;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk(done8 == 1'b0, {nm, "_done_one_cycle"}, done8, 0);
            chk(p8 == exp, {nm, "_p_stable"}, p8, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[$];
        int d0;
        int t;
        int got;
        int last;

        vt.push_back('{8'd15,  8'd15,  1'b0, 16'd225,   "v15x15"});
        vt.push_back('{8'd255, 8'd255, 1'b0, 16'd65025, "v255x255"});
        vt.push_back('{8'd0,   8'd200, 1'b0, 16'd0,     "v0x200"});
        vt.push_back('{8'd200, 8'd0,   1'b0, 16'd0,     "v200x0"});
        vt.push_back('{8'd1,   8'd1,   1'b0, 16'd1,     "v1x1"});
        vt.push_back('{8'd128, 8'd2,   1'b0, 16'd256,   "v128x2"});
        vt.push_back('{8'd171, 8'd205, 1'b0, 16'd35055, "v171x205"});
        vt.push_back('{8'd255, 8'd1,   1'b0, 16'd255,   "v255x1"});
`ifdef SEQ_MULTIPLIER_SIGNED_EN
        vt.push_back('{8'hFD,  8'd5,   1'b1, 16'hFFF1,  "s_m3x5"});
        vt.push_back('{8'h80,  8'h80,  1'b1, 16'd16384, "s_m128xm128"});
        vt.push_back('{8'hFD,  8'd5,   1'b0, 16'd1265,  "u_253x5"});
        vt.push_back('{8'h7F,  8'hFF,  1'b1, 16'hFF81,  "s_127xm1"});
`endif

        #2;
        chk(busy8 == 1'b0, "rst_busy", busy8, 0);
        chk(done8 == 1'b0, "rst_done", done8, 0);
        chk(p8 == 16'd0, "rst_p", p8, 0);
        chk(busy4 == 1'b0, "rst_busy4", busy4, 0);

        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk(busy8 == 1'b0, "idle_no_start", busy8, 0);
        end

        foreach (vt[i]) run8(vt[i].a, vt[i].b, vt[i].sm, vt[i].exp, vt[i].nm);
        sm8 = 1'b0;

        // start during RUN ignored, operand changes after capture ignored
        d0 = dn8;
        a8 = 8'd12;
        b8 = 8'd11;
        start8 = 1'b1;
        q8.push_back(16'd132);
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start8 = 1'b1;
        a8 = 8'd200;
        b8 = 8'd200;
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'd7;
        b8 = 8'd9;
        repeat (15) @(negedge clk);
        chk(dn8 - d0 == 1, "ignored_start_one_done", dn8 - d0, 1);
        chk(p8 == 16'd132, "ignored_start_p", p8, 132);
        last_p8 = 16'd132;

        // reset in the 4th RUN cycle
        d0 = dn8;
        a8 = 8'd100;
        b8 = 8'd3;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        chk(busy8 == 1'b1, "pre_abort_busy", busy8, 1);
        rst = 1'b1;
        #1;
        chk(busy8 == 1'b0, "abort_busy", busy8, 0);
        chk(done8 == 1'b0, "abort_done", done8, 0);
        chk(p8 == 16'd0, "abort_p", p8, 0);
        last_p8 = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk(dn8 == d0, "abort_no_done", dn8 - d0, 0);
        run8(8'd100, 8'd3, 1'b0, 16'd300, "after_rst");

        // WIDTH=4 with start held high: one product every 6 cycles
        a4 = 4'd9;
        b4 = 4'd13;
        start4 = 1'b1;
        t = 0;
        got = 0;
        last = 0;
        while (got < 4 && t < 80) begin
            @(negedge clk);
            t++;
            if (done4) begin
                chk(p4 == 8'd117, "w4_p", p4, 117);
                if (got == 0) chk(t == 5, "w4_first_latency", t, 5);
                else chk(t - last == 6, "w4_period", t - last, 6);
                last = t;
                got++;
            end
        end
        chk(got == 4, "w4_done_count", got, 4);
        start4 = 1'b0;

        repeat (3) @(negedge clk);
        chk(q8.size() == 0, "sb_drained", q8.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request a multiply; sampled only in IDLE.
REQ-005 The block SHALL have port a, input, WIDTH bits: multiplicand, captured on an accepted start.
REQ-006 The block SHALL have port b, input, WIDTH bits: multiplier, captured on an accepted start.
REQ-007 The block SHALL have port busy, output, 1 bit: high while in RUN.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse marking p valid.
REQ-009 The block SHALL have port p, output, 2*WIDTH bits: product register.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-011 IDLE with start=1 SHALL capture a and b, clear the accumulator, load the iteration counter with WIDTH-1 and go to RUN; start=0 SHALL leave the block in IDLE.
REQ-012 Each RUN cycle SHALL add the multiplicand to the upper accumulator half when the multiplier LSB is 1, keep the carry-out, shift the {carry, accumulator} right by one bit and decrement the counter.
REQ-013 RUN SHALL go to DONE in the cycle where the counter equals 0, i.e. after exactly WIDTH RUN cycles.
REQ-014 DONE SHALL load p with the full 2*WIDTH-bit product, assert done for that one cycle and return to IDLE on the next cycle.
REQ-015 Latency SHALL be fixed: done is high in the cycle after the edge that ends the WIDTH-th RUN cycle (WIDTH+1 edges after start is sampled), independent of operand values, including zero operands.
REQ-016 p SHALL hold its value from DONE until the next DONE; it SHALL NOT change during RUN.
REQ-017 start asserted in RUN or DONE SHALL be ignored and SHALL NOT be queued.
REQ-018 Changes on a and b after capture SHALL NOT affect the result in progress.
REQ-019 The product SHALL be exact, with no truncation or overflow, for all operand values (for example (2^WIDTH-1)^2).
REQ-020 start may be held high continuously; a new operation SHALL begin on each visit to IDLE, giving one product every WIDTH+2 cycles.

Reset
REQ-021 While rst=1 the block SHALL force state=IDLE, busy=0, done=0, p=0, and clear the counter and accumulator, immediately and without a clock edge.
REQ-022 rst asserted mid-RUN SHALL abort the operation, produce no done pulse and leave p=0.
REQ-023 The first start SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-024 With macro SEQ_MULTIPLIER_SIGNED_EN defined, the block SHALL add input port signed_mode, 1 bit, captured with a and b on an accepted start.
REQ-025 When signed_mode=1, the block SHALL treat a and b as two's complement, multiply their magnitudes, and negate the result in DONE when the operand signs differ.
REQ-026 Latency SHALL remain WIDTH+1 edges after start in both modes.
REQ-027 Without SEQ_MULTIPLIER_SIGNED_EN, the signed_mode port SHALL be absent and all operands SHALL be treated as unsigned.

Structure
REQ-028 Package seq_mult_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the localparam width helpers: counter width $clog2(WIDTH) and product width 2*WIDTH.
REQ-029 The add step SHALL be a single sub-module, mult_add_stage: a combinational WIDTH-bit adder with carry-out that generalises the existing half/full-adder cells.
REQ-030 seq_multiplier SHALL instantiate mult_add_stage once and own the FSM, counter and registers.

Verification
REQ-031 WIDTH=8, a=15, b=15, pulse start -> busy for 8 cycles, done 9 edges after start with p=225, p then stable.
REQ-032 WIDTH=8, a=255, b=255 -> p=65025; a=0, b=200 -> p=0 with the same 9-edge latency.
REQ-033 Pulse start again 3 cycles into RUN with new operands -> ignored; the first result completes unchanged, with only one done pulse.
REQ-034 Assert rst in the 4th RUN cycle -> busy=0, p=0 immediately, no done pulse; the next start yields a correct product.
REQ-035 WIDTH=4, hold start high with a=9, b=13 -> p=117 every 6 cycles.
REQ-036 With SEQ_MULTIPLIER_SIGNED_EN, WIDTH=8, signed_mode=1: a=-3, b=5 -> p=16'hFFF1; a=-128, b=-128 -> p=16384; signed_mode=0, a=8'hFD, b=5 -> p=1265.
